// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit words from instruction memory and hands them to decode
// over valid/ready, with branch redirect support. Define FETCH_PERF_EN to add the fetchCount counter.
module instr_fetch_unit #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imemReq,
    output logic [PC_WIDTH-1:0] imemAddr,
    input  logic                imemAck,
    input  logic [31:0]         imemData,
    output logic                instrValid,
    input  logic                instrReady,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] instrPC,
    output logic [6:0]          opcodeCtrl,
    output logic                illegalOp,
    input  logic                branchTaken,
`ifdef FETCH_PERF_EN
    input  logic [PC_WIDTH-1:0] branchTarget,
    output logic [31:0]         fetchCount
`else
    input  logic [PC_WIDTH-1:0] branchTarget
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] req_addr;
    logic [PC_WIDTH-1:0] target;
    logic                transfer;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011: is_legal = 1'b1;
            default:                                                    is_legal = 1'b0;
        endcase
    endfunction

    assign target     = {branchTarget[PC_WIDTH-1:2], 2'b00};
    assign transfer   = instrValid & instrReady;
    assign imemReq    = (state == REQ) || (state == DROP);
    assign imemAddr   = req_addr;
    assign opcodeCtrl = instruction[6:0];

    // Redirect is decoded ahead of the per-state cases since it wins in every state;
    // an un-acked request must still complete, so it parks in DROP with its address held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            instrValid  <= 1'b0;
            instruction <= NOP;
            instrPC     <= RESET_PC;
            illegalOp   <= 1'b0;
        end else if (branchTaken) begin
            pc         <= target;
            instrValid <= 1'b0;
            illegalOp  <= 1'b0;
            if (((state == REQ) || (state == DROP)) && !imemAck) begin
                state <= DROP;
            end else begin
                state    <= REQ;
                req_addr <= target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    req_addr <= pc;
                end
                REQ: begin
                    if (imemAck) begin
                        instruction <= imemData;
                        instrPC     <= req_addr;
                        instrValid  <= 1'b1;
                        illegalOp   <= ~is_legal(imemData[6:0]);
                        pc          <= req_addr + PC_WIDTH'(4);
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instrReady) begin
                        instrValid <= 1'b0;
                        illegalOp  <= 1'b0;
                        req_addr   <= pc;
                        state      <= REQ;
                    end
                end
                DROP: begin
                    if (imemAck) begin
                        req_addr <= pc;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCount <= '0;
        end else if (transfer) begin
            fetchCount <= fetchCount + 32'd1;
        end
    end
`else
    logic unused_transfer;
    assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed bring-up sequence, then randomized memory latency,
// backpressure and redirects checked against a delivered-instruction-stream model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic [6:0]  opcodeCtrl;
    logic        illegalOp;
    logic        branchTaken;
    logic [31:0] branchTarget;

    logic        n_req;
    logic [7:0]  n_addr;
    logic        n_valid;
    logic [31:0] n_instr;
    logic [7:0]  n_pc;
    logic [6:0]  n_opc;
    logic        n_ill;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] n_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [6:0] LEGAL [5] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instrValid(instrValid), .instrReady(instrReady), .instruction(instruction),
        .instrPC(instrPC), .opcodeCtrl(opcodeCtrl), .illegalOp(illegalOp),
        .branchTaken(branchTaken),
`ifdef FETCH_PERF_EN
        .branchTarget(branchTarget), .fetchCount(fetchCount)
`else
        .branchTarget(branchTarget)
`endif
    );

    instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .imemReq(n_req), .imemAddr(n_addr), .imemAck(imemAck), .imemData(imemData),
        .instrValid(n_valid), .instrReady(instrReady), .instruction(n_instr),
        .instrPC(n_pc), .opcodeCtrl(n_opc), .illegalOp(n_ill),
        .branchTaken(branchTaken),
`ifdef FETCH_PERF_EN
        .branchTarget(branchTarget[7:0]), .fetchCount(n_count)
`else
        .branchTarget(branchTarget[7:0])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic [6:0] op);
        legal = 1'b0;
        for (int unsigned i = 0; i < 5; i++) if (LEGAL[i] == op) legal = 1'b1;
    endfunction

    // Memory contents: a hash of the address, mostly legal opcodes with some arbitrary ones.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        if (h[2:0] < 3'd5) op = LEGAL[h[2:0]];
        else               op = h[13:7];
        return {h[31:7], op};
    endfunction

    logic [31:0] exp_pc;
    int unsigned xfers;
    int unsigned mem_wait;
    int unsigned idle_run;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    logic        rdy, br, timed_out;
    logic [31:0] tgt, w;

    initial begin
        rst_n = 1'b1; imemAck = 1'b0; imemData = '0; instrReady = 1'b0;
        branchTaken = 1'b0; branchTarget = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_req",   32'(imemReq), 32'd0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_pc",    instrPC, 32'h0);
        check("rst_ill",   32'(illegalOp), 32'd0);
        rst_n = 1'b1;
        check("idle_req",  32'(imemReq), 32'd0);
        tick();
        check("first_req", 32'(imemReq), 32'd1);
        check("first_addr", imemAddr, 32'h0);

        // Streaming, latency 1, ready held high
        instrReady = 1'b1;
        imemAck = 1'b1; imemData = 32'h0050_0093;
        tick(); imemAck = 1'b0;
        check("s0_valid", 32'(instrValid), 32'd1);
        check("s0_pc",    instrPC, 32'h0);
        check("s0_instr", instruction, 32'h0050_0093);
        check("s0_opc",   32'(opcodeCtrl), 32'h13);
        check("s0_noreq", 32'(imemReq), 32'd0);
        tick();
        check("s1_addr",  imemAddr, 32'h4);
        imemAck = 1'b1; imemData = 32'h00A0_0113;
        tick(); imemAck = 1'b0;
        check("s1_pc",    instrPC, 32'h4);
        check("s1_instr", instruction, 32'h00A0_0113);
        tick();
        check("s2_req",   32'(imemReq), 32'd1);
        check("s2_addr",  imemAddr, 32'h8);

        // Redirect while the request to 0x8 is outstanding; target low bits must be masked
        branchTaken = 1'b1; branchTarget = 32'h41;
        tick(); branchTaken = 1'b0;
        check("drop_req",  32'(imemReq), 32'd1);
        check("drop_addr", imemAddr, 32'h8);
        imemAck = 1'b1; imemData = 32'h0000_007F;
        tick(); imemAck = 1'b0;
        check("drop_novalid", 32'(instrValid), 32'd0);
        check("redir_addr",   imemAddr, 32'h40);

        // Illegal opcode under backpressure
        instrReady = 1'b0;
        imemAck = 1'b1; imemData = 32'h0000_007F;
        tick(); imemAck = 1'b0;
        check("ill_valid", 32'(instrValid), 32'd1);
        check("ill_flag",  32'(illegalOp), 32'd1);
        check("ill_opc",   32'(opcodeCtrl), 32'h7F);
        check("ill_pc",    instrPC, 32'h40);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", instruction, 32'h0000_007F);
            check("bp_noreq", 32'(imemReq), 32'd0);
        end
        instrReady = 1'b1;
        tick();
        check("bp_next_addr", imemAddr, 32'h44);
        check("bp_next_req",  32'(imemReq), 32'd1);
`ifdef FETCH_PERF_EN
        check("perf_three", fetchCount, 32'd3);
`endif
        imemAck = 1'b1; imemData = 32'h0000_2083;
        tick(); imemAck = 1'b0;
        check("lw_legal", 32'(illegalOp), 32'd0);
        check("lw_opc",   32'(opcodeCtrl), 32'h03);
        tick();
        check("lw_next", imemAddr, 32'h48);

        // Wrap: redirect to top word, next sequential fetch must be 0
        branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick(); branchTaken = 1'b0;
        imemAck = 1'b1; imemData = 32'h0;
        tick();
        check("wrap_addr",  imemAddr, 32'hFFFF_FFFC);
        check("wrap8_addr", 32'(n_addr), 32'hFC);
        imemData = 32'h0000_0013;
        tick(); imemAck = 1'b0;
        check("wrap_pc", instrPC, 32'hFFFF_FFFC);
        tick();
        check("wrap_next",  imemAddr, 32'h0);
        check("wrap8_next", 32'(n_addr), 32'h0);

        // Reset mid-request, then a late ack in the idle cycle
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req",   32'(imemReq), 32'd0);
        check("midrst_instr", instruction, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        imemAck = 1'b1; imemData = 32'h0000_007F;
        tick(); imemAck = 1'b0;
        check("late_ack_valid", 32'(instrValid), 32'd0);
        check("late_ack_addr",  imemAddr, 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_rst", fetchCount, 32'd0);
`endif

        // Randomized phase: the model tracks the address of the next instruction decode must see
        exp_pc = 32'h0; xfers = 0; mem_wait = 0; idle_run = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; timed_out = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instrValid) begin
                w = memword(exp_pc);
                check("rnd_pc",    instrPC, exp_pc);
                check("rnd_instr", instruction, w);
                check("rnd_opc",   32'(opcodeCtrl), 32'(w[6:0]));
                check("rnd_ill",   32'(illegalOp), 32'(!legal(w[6:0])));
                idle_run = 0;
            end else begin
                check("rnd_ill0", 32'(illegalOp), 32'd0);
                idle_run++;
            end
            check("rnd_nofetch_hold", 32'(instrValid & imemReq), 32'd0);
            if (imemReq && prev_req && !prev_ack) check("rnd_addr_stable", imemAddr, prev_addr);
            if (idle_run > 100) begin
                check("rnd_watchdog", 32'(idle_run), 32'd0);
                timed_out = 1'b1;
                break;
            end

            rdy = ($urandom_range(3, 0) != 0);
            br  = ($urandom_range(31, 0) == 0);
            tgt = $urandom;
            if (instrValid && rdy) begin
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (br) exp_pc = tgt & ~32'h3;

            if (imemAck) begin
                imemAck = 1'b0;
                mem_wait = $urandom_range(3, 0);
            end else if (imemReq) begin
                if (mem_wait == 0) begin
                    imemAck = 1'b1;
                    imemData = memword(imemAddr);
                end else begin
                    mem_wait--;
                end
            end
            prev_req = imemReq; prev_addr = imemAddr; prev_ack = imemAck;
            instrReady = rdy; branchTaken = br; branchTarget = tgt;
            tick();
        end
        branchTaken = 1'b0;
`ifdef FETCH_PERF_EN
        if (!timed_out) check("perf_rnd", fetchCount, 32'(xfers));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
